// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment glyph table for the 7-segment scanner.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned VALUE_W    = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Standard 0-F glyphs (lower-case b and d so they differ from 8 and 0)
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to 7-segment pattern decoder.
// Ports:
//   i_nibble  4-bit hex digit
//   o_seg_c   active-low segments {g,f,e,d,c,b,a}, combinational
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = hex_to_seg(i_nibble);

endmodule

// File: rtl/led_seg7_scan.sv
// Time-multiplexed 4-digit hex display driver for a common-anode 7-segment module.
// A frame-synchronous shadow copy of i_value avoids tearing; the first BLANK_CYC
// cycles of each digit slot keep all anodes off to prevent ghosting.
// Optional macro SEG7_LZ_BLANK_EN: suppress leading zeros on digits 3..1.
// Ports:
//   i_clk    system clock
//   i_arst   asynchronous active-high reset
//   i_value  16-bit word to display, digit n = i_value[4n+3:4n]
//   i_en     display enable (scanning continues while low)
//   o_an     active-low anode selects, o_an[0] = rightmost digit
//   o_seg    active-low segments {g,f,e,d,c,b,a}
//   o_dp_n   active-low decimal point, held off
module led_seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50_000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_en,
    output logic [3:0]         o_an,
    output logic [6:0]         o_seg,
    output logic               o_dp_n
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VALUE_W-1:0] shd_q, shd_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_n_q;

    logic [3:0] nibble_c;
    logic [6:0] digit_seg_c;
    logic       lead_zero_c;
    logic       active_c;

    // Digit mux feeding the single shared decoder
    assign nibble_c = shd_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nibble (nibble_c),
        .o_seg_c  (digit_seg_c)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Digit k>0 is a leading zero when it and every digit above it are zero
    assign lead_zero_c = (idx_q != '0) && ((shd_q >> {idx_q, 2'b00}) == '0);
`else
    assign lead_zero_c = 1'b0;
`endif

    assign active_c = i_en && (32'(cnt_q) >= BLANK_CYC) && !lead_zero_c;

    // Prescaler, digit index, shadow load and output decode
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        shd_d = shd_q;
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;

        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end

        if ((cnt_q == '0) && (idx_q == '0)) begin
            shd_d = i_value;
        end

        if (active_c) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = digit_seg_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            shd_q  <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            shd_q  <= shd_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= 1'b1;
        end
    end

    assign o_an   = an_q;
    assign o_seg  = seg_q;
    assign o_dp_n = dp_n_q;

endmodule

// File: tb/tb_led_seg7_scan.sv
// Self-checking bench for led_seg7_scan with REFRESH_DIV=8, BLANK_CYC=2.
// A cycle model pushes the expected pins per clock; each scenario pops and compares.
module tb_led_seg7_scan;

    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic [15:0] i_value;
    logic        i_en;
    logic [3:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] exp_q[$];

    int unsigned m_cnt;
    logic [1:0]  m_idx;
    logic [15:0] m_shd;

    led_seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_value (i_value),
        .i_en    (i_en),
        .o_an    (o_an),
        .o_seg   (o_seg),
        .o_dp_n  (o_dp_n)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Pins expected after the next clock edge, from the model's pre-edge state
    function automatic logic [11:0] model_out();
        logic lz;
        if (i_arst || !i_en || m_cnt < BC) return 12'hFFF;
        lz = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        lz = (m_idx != 2'd0) && ((m_shd >> (4 * m_idx)) == 16'h0);
`endif
        if (lz) return 12'hFFF;
        return {~(4'b0001 << m_idx), glyph(m_shd[4*m_idx +: 4]), 1'b1};
    endfunction

    // Advance one clock: push expectation, step model, return at the falling edge
    task automatic tick();
        exp_q.push_back(model_out());
        @(posedge i_clk);
        if (i_arst) begin
            m_cnt = 0; m_idx = 2'd0; m_shd = 16'h0;
        end else begin
            if (m_cnt == 0 && m_idx == 2'd0) m_shd = i_value;
            if (m_cnt == RD - 1) begin
                m_cnt = 0; m_idx = m_idx + 2'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        logic [11:0] e, got;
        i_arst = 1'b1; i_en = 1'b1; i_value = 16'h5003;
        repeat (3) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", got, e); end
            n_checks++;
            if (got !== 12'hFFF) begin n_fail++; $display("FAIL reset_hold: got %h want fff", got); end
        end
        i_arst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL release_sb: got %h want %h", got, e); end
            n_checks++;
            if (k < 3 && o_an !== 4'hF) begin n_fail++; $display("FAIL release_blank: cyc %0d an=%h want f", k, o_an); end
            if (k == 3 && o_an !== 4'hE) begin n_fail++; $display("FAIL release_first_an: an=%h want e", o_an); end
        end
    endtask

    task automatic test_frame();
        logic [11:0] e, got;
        logic [6:0] want_seg [4] = '{7'h30, 7'h40, 7'h40, 7'h12};
        int act [4] = '{0, 0, 0, 0};
        int blanks = 0;
        for (int g = 0; g < 64 && !(m_cnt == 0 && m_idx == 2'd0); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL frame_sync_sb: got %h want %h", got, e); end
        end
        repeat (32) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL frame_sb: got %h want %h", got, e); end
            if (o_an === 4'hF) blanks++;
            for (int d = 0; d < 4; d++) begin
                if (o_an === ~(4'b0001 << d)) begin
                    act[d]++;
                    n_checks++;
                    if (o_seg !== want_seg[d]) begin n_fail++; $display("FAIL frame_seg: digit %0d seg=%h want %h", d, o_seg, want_seg[d]); end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (act[d] != 6) begin n_fail++; $display("FAIL frame_active: digit %0d cycles=%0d want 6", d, act[d]); end
        end
        n_checks++;
        if (blanks != 8) begin n_fail++; $display("FAIL frame_blank: cycles=%0d want 8", blanks); end
    endtask

    task automatic test_tearing();
        logic [11:0] e, got;
        int slot3 = 0;
        int act = 0;
        for (int g = 0; g < 64 && !(m_idx == 2'd2 && m_cnt == 3); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL tear_pre_sb: got %h want %h", got, e); end
        end
        i_value = 16'hFFFF;
        for (int g = 0; g < 64 && !(m_cnt == 0 && m_idx == 2'd0); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL tear_sb: got %h want %h", got, e); end
            if (o_an === 4'h7) begin
                slot3++;
                n_checks++;
                if (o_seg !== 7'h12) begin n_fail++; $display("FAIL tear_slot3: seg=%h want 12", o_seg); end
            end
        end
        n_checks++;
        if (slot3 != 6) begin n_fail++; $display("FAIL tear_slot3_cnt: cycles=%0d want 6", slot3); end
        repeat (32) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL tear_next_sb: got %h want %h", got, e); end
            if (o_an !== 4'hF) begin
                act++;
                n_checks++;
                if (o_seg !== 7'h0E) begin n_fail++; $display("FAIL tear_next_seg: an=%h seg=%h want 0e", o_an, o_seg); end
            end
        end
        n_checks++;
        if (act != 24) begin n_fail++; $display("FAIL tear_next_cnt: cycles=%0d want 24", act); end
    endtask

    task automatic test_enable();
        logic [11:0] e, got;
        for (int g = 0; g < 64 && !(m_idx == 2'd1 && m_cnt == 3); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL en_pre_sb: got %h want %h", got, e); end
        end
        i_en = 1'b0;
        #1;
        n_checks++;
        if (o_an !== 4'hD) begin n_fail++; $display("FAIL en_latency: an=%h want d", o_an); end
        repeat (5) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL en_off_sb: got %h want %h", got, e); end
            n_checks++;
            if (got !== 12'hFFF) begin n_fail++; $display("FAIL en_off: got %h want fff", got); end
        end
        i_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL en_on_sb: got %h want %h", got, e); end
            n_checks++;
            if (k < 3 && o_an !== 4'hF) begin n_fail++; $display("FAIL en_resume_blank: cyc %0d an=%h want f", k, o_an); end
            if (k == 3 && {o_an, o_seg} !== {4'hB, 7'h0E}) begin n_fail++; $display("FAIL en_resume_slot: an=%h seg=%h want b/0e", o_an, o_seg); end
        end
        for (int g = 0; g < 64 && !(m_cnt == 0 && m_idx == 2'd0); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL en_tail_sb: got %h want %h", got, e); end
        end
    endtask

    task automatic test_lz();
        logic [11:0] e, got;
        int act;
        int want_act;
`ifdef SEG7_LZ_BLANK_EN
        want_act = 6;
`else
        want_act = 24;
`endif
        i_value = 16'h0003;
        for (int g = 0; g < 64 && !(m_cnt == 0 && m_idx == 2'd0); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL lz_sync_sb: got %h want %h", got, e); end
        end
        for (int f = 0; f < 2; f++) begin
            act = 0;
            for (int c = 0; c < 32; c++) begin
                tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
                if (got !== e) begin n_fail++; $display("FAIL lz_sb: frame %0d got %h want %h", f, got, e); end
                if (f == 0 && c == 0) i_value = 16'h0000;
                if (o_an !== 4'hF) act++;
                if (o_an === 4'hE) begin
                    n_checks++;
                    if (o_seg !== (f == 0 ? 7'h30 : 7'h40)) begin n_fail++; $display("FAIL lz_digit0: frame %0d seg=%h", f, o_seg); end
                end
            end
            n_checks++;
            if (act != want_act) begin n_fail++; $display("FAIL lz_active: frame %0d cycles=%0d want %0d", f, act, want_act); end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e, got;
        i_value = 16'h5003;
        for (int g = 0; g < 64 && !(m_idx == 2'd2 && m_cnt == 4); g++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL arst_pre_sb: got %h want %h", got, e); end
        end
        n_checks++;
        if ({o_an, o_seg} !== {4'hB, 7'h40}) begin n_fail++; $display("FAIL arst_pre: an=%h seg=%h want b/40", o_an, o_seg); end
        #2 i_arst = 1'b1;
        #1;
        got = {o_an, o_seg, o_dp_n}; n_checks++;
        if (got !== 12'hFFF) begin n_fail++; $display("FAIL arst_immediate: got %h want fff", got); end
        repeat (2) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL arst_hold_sb: got %h want %h", got, e); end
        end
        i_arst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL arst_rel_sb: got %h want %h", got, e); end
            if (k == 3) begin
                n_checks++;
                if ({o_an, o_seg} !== {4'hE, 7'h30}) begin n_fail++; $display("FAIL arst_restart: an=%h seg=%h want e/30", o_an, o_seg); end
            end
        end
        repeat (32) begin
            tick(); e = exp_q.pop_front(); got = {o_an, o_seg, o_dp_n}; n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL arst_tail_sb: got %h want %h", got, e); end
        end
    endtask

    initial begin
        m_cnt = 0; m_idx = 2'd0; m_shd = 16'h0;
        i_arst = 1'b1; i_en = 1'b1; i_value = 16'h0;
        test_reset();
        test_frame();
        test_tearing();
        test_enable();
        test_lz();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: %0d left want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
